// File: rtl/defines.sv
// Shared core definitions: data width, instruction size, fetch queue entry.
// No ports; imported by the fetch stage files.
package defines;

   localparam int DATA_WIDTH  = 32;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: imem request/response, redirect and decode handshake.
// master = fetch unit side, slave = memory/execute/decode side.
interface fetch_unit_if;
   import defines::*;

   logic                  imem_req_o;
   logic [DATA_WIDTH-1:0] imem_addr_o;
   logic                  imem_gnt_i;
   logic                  imem_rvalid_i;
   logic [DATA_WIDTH-1:0] imem_rdata_i;
   logic                  redirect_i;
   logic [DATA_WIDTH-1:0] redirect_pc_i;
   logic                  id_valid_o;
   logic                  id_ready_i;
   logic [DATA_WIDTH-1:0] id_instr_o;
   logic [DATA_WIDTH-1:0] id_pc_o;
   logic [DATA_WIDTH-1:0] id_pc_plus4_o;

   modport master (
      output imem_req_o, imem_addr_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      input  redirect_i, redirect_pc_i,
      output id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
      input  id_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      output redirect_i, redirect_pc_i,
      input  id_valid_o, id_instr_o, id_pc_o, id_pc_plus4_o,
      output id_ready_i
   );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue of {pc, instr} entries; flush beats push and pop.
// Ports: clk, rst_n, push/push_data, pop, flush, full, empty, count, head.
module fetch_fifo
   import defines::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign do_pop = pop && !empty;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, response queue, redirects.
// Ports: clk, rst_n (async, active-low), bus (fetch_unit_if.master).
module fetch_unit
   import defines::*;
#(
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(INSTR_BYTES);

   logic [DATA_WIDTH-1:0] fetch_pc;
   logic [DATA_WIDTH-1:0] resp_pc;
   logic [DATA_WIDTH-1:0] target;
   logic [CW-1:0]         outstanding;
   logic [CW-1:0]         discard;
   logic [CW-1:0]         count;
   logic [CW:0]           in_use;
   logic                  full;
   logic                  empty;
   logic                  grant;
   logic                  push;
   logic                  pop;
   fetch_entry_t          head;
   fetch_entry_t          entry;

   assign target = {bus.redirect_pc_i[DATA_WIDTH-1:2], 2'b00};

   // Credits use registered counts only, so a same-cycle pop frees nothing.
   assign in_use = {1'b0, count} + {1'b0, outstanding};

   assign bus.imem_req_o  = rst_n && !bus.redirect_i && (in_use < DEPTH_C);
   assign bus.imem_addr_o = fetch_pc;

   assign grant = bus.imem_req_o && bus.imem_gnt_i;
   assign push  = bus.imem_rvalid_i && (discard == '0)
                  && !bus.redirect_i && !full;
   assign pop   = bus.id_valid_o && bus.id_ready_i;
   assign entry = '{pc: resp_pc, instr: bus.imem_rdata_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding + CW'(grant)
                        - CW'(bus.imem_rvalid_i);
         if (bus.redirect_i) begin
            // Everything still in flight belongs to the old path.
            fetch_pc <= target;
            resp_pc  <= target;
            discard  <= outstanding - CW'(bus.imem_rvalid_i);
         end else begin
            if (grant) fetch_pc <= fetch_pc + STEP;
            if (push)  resp_pc  <= resp_pc + STEP;
            if (bus.imem_rvalid_i && (discard != '0))
               discard <= discard - CW'(1);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (entry),
      .pop       (pop),
      .flush     (bus.redirect_i),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .head      (head)
   );

   assign bus.id_valid_o    = !empty;
   assign bus.id_instr_o    = head.instr;
   assign bus.id_pc_o       = head.pc;
   assign bus.id_pc_plus4_o = head.pc + STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a stream-level reference model.
// Drives imem, redirect and decode from the slave side of fetch_unit_if.
module tb_fetch_unit;
   import defines::*;

   localparam logic [31:0] RST_PC = 32'h100;
   localparam logic [31:0] KEY    = 32'hA5A5_0000;
   localparam int          DEPTH  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // memory model: in-order queue of granted addresses and due cycles
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   int cyc = 0;
   int gnt_pct = 100, rdy_pct = 100, redir_pm = 0;
   int lat_min = 1, lat_max = 1;
   logic force_redir = 1'b0;
   logic [31:0] force_tgt = '0;

   logic [31:0] exp_req, exp_pc;
   int first_gnt, first_valid, delivered = 0, coinc = 0;

   logic p_valid, p_ready, p_redir, p_req, p_gnt;
   logic [31:0] p_pc, p_instr, p_addr;

   task automatic clear_prev();
      p_valid = 0; p_ready = 0; p_redir = 0; p_req = 0; p_gnt = 0;
      p_pc = '0; p_instr = '0; p_addr = '0;
   endtask

   task automatic step();
      logic redir, rv, req, gnt, valid, ready;
      logic [31:0] tgt, addr, pc, instr;
      int due, lat;
      @(negedge clk);
      gnt   = ($urandom_range(99) < gnt_pct);
      ready = ($urandom_range(99) < rdy_pct);
      redir = 1'b0;
      tgt   = '0;
      if (force_redir) begin
         redir = 1'b1; tgt = force_tgt; force_redir = 1'b0;
      end else if (redir_pm > 0 && $urandom_range(999) < redir_pm) begin
         redir = 1'b1; tgt = $urandom;
      end
      rv = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
      bus.imem_gnt_i    = gnt;
      bus.id_ready_i    = ready;
      bus.redirect_i    = redir;
      bus.redirect_pc_i = tgt;
      bus.imem_rvalid_i = rv;
      bus.imem_rdata_i  = rv ? (mq_addr[0] ^ KEY) : $urandom;
      #1;
      req   = bus.imem_req_o;
      addr  = bus.imem_addr_o;
      valid = bus.id_valid_o;
      pc    = bus.id_pc_o;
      instr = bus.id_instr_o;

      if (p_redir) check("valid_after_redirect", valid, 0);
      if (p_valid && !p_ready && !p_redir) begin
         check("hold_valid", valid, 1);
         check("hold_pc", pc, p_pc);
         check("hold_instr", instr, p_instr);
      end
      if (p_req && !p_gnt && !p_redir && !redir) begin
         check("stall_req", req, 1);
         check("stall_addr", addr, p_addr);
      end
      if (redir) check("req_in_redirect", req, 0);
      if (req) check("req_addr", addr, exp_req);
      if (valid) check("pc_plus4", bus.id_pc_plus4_o, pc + 32'd4);
      if (valid && first_valid < 0) first_valid = cyc;
      if (redir && rv && valid && ready) coinc++;
      if (valid && ready && !redir) begin
         check("id_pc", pc, exp_pc);
         check("id_instr", instr, exp_pc ^ KEY);
         exp_pc += 32'd4;
         delivered++;
      end

      if (req && gnt) begin
         lat = $urandom_range(lat_max, lat_min);
         due = cyc + lat;
         if (mq_due.size() > 0 && due <= mq_due[$]) due = mq_due[$] + 1;
         mq_addr.push_back(addr);
         mq_due.push_back(due);
         check("inflight_bound", 32'(mq_addr.size() <= DEPTH), 1);
         exp_req += 32'd4;
         if (first_gnt < 0) first_gnt = cyc;
      end
      if (rv) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (redir) begin
         exp_req = tgt & ~32'd3;
         exp_pc  = tgt & ~32'd3;
      end

      p_valid = valid; p_ready = ready; p_redir = redir;
      p_req = req; p_gnt = gnt; p_pc = pc; p_instr = instr; p_addr = addr;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_req", bus.imem_req_o, 0);
      check("rst_valid", bus.id_valid_o, 0);
      check("rst_addr", bus.imem_addr_o, RST_PC);
      check("rst_instr", bus.id_instr_o, 0);
      check("rst_pc", bus.id_pc_o, 0);
      check("rst_pc_plus4", bus.id_pc_plus4_o, 4);
      bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.imem_rdata_i = '0;
      bus.redirect_i = 0; bus.redirect_pc_i = '0; bus.id_ready_i = 0;
      mq_addr.delete();
      mq_due.delete();
      clear_prev();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("req_after_reset", bus.imem_req_o, 1);
      exp_req = RST_PC;
      exp_pc = RST_PC;
      first_gnt = -1;
      first_valid = -1;
   endtask

   initial begin
      int d0, n;
      bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.imem_rdata_i = '0;
      bus.redirect_i = 0; bus.redirect_pc_i = '0; bus.id_ready_i = 0;
      clear_prev();
      do_reset();

      // streaming with 1-cycle memory
      gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
      repeat (12) step();
      check("first_latency", 32'(first_valid - first_gnt), 2);
      check("stream_progress", 32'(delivered >= 6), 1);

      // backpressure
      rdy_pct = 0;
      repeat (5) step();
      check("bp_req_drop", bus.imem_req_o, 0);
      rdy_pct = 100;
      d0 = delivered;
      repeat (10) step();
      check("bp_resume", 32'(delivered > d0), 1);

      // redirect with two requests in flight, latency 3
      lat_min = 3; lat_max = 3;
      n = 0;
      while (mq_addr.size() != 2 && n < 30) begin
         step();
         n++;
      end
      check("reach_two_inflight", 32'(mq_addr.size()), 2);
      force_redir = 1'b1; force_tgt = 32'h2002;
      d0 = delivered;
      repeat (20) step();
      check("redirect_progress", 32'(delivered > d0), 1);

      // grant stall
      lat_min = 1; lat_max = 1;
      do_reset();
      gnt_pct = 100;
      step();
      gnt_pct = 0;
      repeat (4) begin
         step();
         check("gstall_addr", bus.imem_addr_o, 32'h104);
         check("gstall_req", bus.imem_req_o, 1);
      end
      gnt_pct = 100;
      d0 = delivered;
      repeat (10) step();
      check("gstall_progress", 32'(delivered > d0), 1);

      // address wrap-around
      force_redir = 1'b1; force_tgt = 32'hFFFF_FFF9;
      d0 = delivered;
      repeat (16) step();
      check("wrap_progress", 32'(delivered >= d0 + 4), 1);

      // randomised mix with frequent redirects
      gnt_pct = 70; rdy_pct = 70; redir_pm = 100;
      lat_min = 1; lat_max = 3;
      d0 = delivered;
      repeat (1500) step();
      check("random_progress", 32'(delivered > d0 + 100), 1);
      check("redirect_rvalid_pop_seen", 32'(coinc > 0), 1);

      // asynchronous reset mid-stream, then restart
      redir_pm = 0; gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
      do_reset();
      d0 = delivered;
      repeat (10) step();
      check("restart_progress", 32'(delivered > d0), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
